// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU encodings, entry layout and flag helper
package alu_pkg;

  localparam int RES_W = 6;
  localparam int OP_W  = 3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef struct packed {
    logic             div0;
    logic             zero;
    logic [1:0]       sel;
    logic [RES_W-1:0] result;
  } alu_entry_t;

  // Returns {div0, zero}; callers pass pre-reduced zero tests so any width works.
  function automatic logic [1:0] alu_flags(input logic [1:0] sel,
                                           input logic       b_zero,
                                           input logic       res_zero);
    return {(sel == OP_DIV) && b_zero, res_zero};
  endfunction

endpackage

// File: rtl/alu_result_buffer_if.sv
// rtl/alu_result_buffer_if.sv - issue and drain handshakes of the result buffer
interface alu_result_buffer_if #(
  parameter int RES_W = 6,
  parameter int OP_W  = 3
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [OP_W-1:0]  in_a;
  logic [OP_W-1:0]  in_b;
  logic [RES_W-1:0] in_result;

  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_data;
  logic [1:0]       out_sel;
  logic             out_zero;
  logic             out_div0;

  modport master (
    output in_valid, in_sel, in_a, in_b, in_result, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_zero, out_div0
  );

  modport slave (
    input  in_valid, in_sel, in_a, in_b, in_result, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_zero, out_div0
  );

endinterface

// File: rtl/alu_fifo.sv
// rtl/alu_fifo.sv - generic synchronous FIFO with occupancy count
module alu_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - flags, queues and drains ALU results; counts rejected issues
module alu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int RES_W = 6,
  parameter int OP_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  alu_result_buffer_if.slave       bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [3:0]               drop_cnt
);

  import alu_pkg::*;

  localparam int ENTRY_W = RES_W + 4;

  logic               push;
  logic               pop;
  logic [1:0]         flags;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  assign flags    = alu_flags(bus.in_sel, bus.in_b == '0, bus.in_result == '0);
  assign wr_entry = {flags, bus.in_sel, bus.in_result};

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign push          = bus.in_valid && !full;
  assign pop           = !empty && bus.out_ready;

  assign {bus.out_div0, bus.out_zero, bus.out_sel, bus.out_data} = rd_entry;

  alu_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // An issue while full is lost even if the head is popped in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (clear) begin
      drop_cnt <= '0;
    end else if (bus.in_valid && full && drop_cnt != 4'hF) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - directed checks for alu_result_buffer
module tb_alu_result_buffer;

  logic       clk;
  logic       rst;
  logic       clear;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic [3:0] drop_cnt;

  int passed;
  int total;

  alu_result_buffer_if #(.RES_W(6), .OP_W(3)) bus ();

  alu_result_buffer #(.DEPTH(4), .RES_W(6), .OP_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .bus      (bus),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic issue(input logic [1:0] sel, input logic [2:0] a, input logic [2:0] b,
                       input logic [5:0] res);
    bus.in_valid  = 1'b1;
    bus.in_sel    = sel;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_result = res;
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    rst           = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'b00;
    bus.in_a      = 3'd0;
    bus.in_b      = 3'd0;
    bus.in_result = 6'd0;
    bus.out_ready = 1'b0;
    #3;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_count", 32'(count), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    tick();
    rst = 1'b0;

    // add 3+2=5, consumer stalled
    issue(2'b00, 3'd3, 3'd2, 6'd5);
    tick();
    bus.in_valid = 1'b0;
    check("add_valid", 32'(bus.out_valid), 1);
    check("add_data", 32'(bus.out_data), 5);
    check("add_zero", 32'(bus.out_zero), 0);
    check("add_count", 32'(count), 1);
    tick();
    check("add_hold_data", 32'(bus.out_data), 5);
    check("add_hold_valid", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("add_drained", 32'(empty), 1);

    // divide by zero, then mul 7*7 pushed while div is popped
    issue(2'b11, 3'd5, 3'd0, 6'd0);
    tick();
    check("div_div0", 32'(bus.out_div0), 1);
    check("div_zero", 32'(bus.out_zero), 1);
    check("div_sel", 32'(bus.out_sel), 3);
    issue(2'b10, 3'd7, 3'd7, 6'd49);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("mul_data", 32'(bus.out_data), 49);
    check("mul_zero", 32'(bus.out_zero), 0);
    check("mul_div0", 32'(bus.out_div0), 0);
    check("mul_count", 32'(count), 1);
    tick();
    bus.out_ready = 1'b0;
    check("mul_drained", 32'(empty), 1);

    // fill to full, then overflow
    for (int i = 1; i <= 5; i++) begin
      issue(2'b00, 3'(i), 3'd0, 6'(i));
      tick();
      if (i == 4) begin
        check("fill_full", 32'(full), 1);
        check("fill_in_ready", 32'(bus.in_ready), 0);
        check("fill_count", 32'(count), 4);
      end
    end
    check("drop_one", 32'(drop_cnt), 1);
    check("drop_count", 32'(count), 4);
    for (int i = 0; i < 15; i++) tick();
    check("drop_saturate", 32'(drop_cnt), 15);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("drain_%0d", k), 32'(bus.out_data), 32'(k));
      tick();
    end
    check("drain_empty", 32'(empty), 1);

    // streaming with consumer always ready
    for (int i = 0; i < 10; i++) begin
      issue(2'b01, 3'd0, 3'd1, 6'(10 + i));
      tick();
      check($sformatf("stream_count_%0d", i), 32'(count), 1);
      check($sformatf("stream_data_%0d", i), 32'(bus.out_data), 32'(10 + i));
    end
    bus.in_valid = 1'b0;
    tick();
    check("stream_empty", 32'(empty), 1);

    // clear overrides push and pop
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(2'b00, 3'd1, 3'd1, 6'(20 + i));
      tick();
    end
    check("pre_clear_count", 32'(count), 3);
    check("pre_clear_drop", 32'(drop_cnt), 15);
    issue(2'b00, 3'd1, 3'd1, 6'd23);
    bus.out_ready = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("clear_count", 32'(count), 0);
    check("clear_empty", 32'(empty), 1);
    check("clear_drop", 32'(drop_cnt), 0);
    check("clear_valid", 32'(bus.out_valid), 0);

    // asynchronous reset mid-stream
    issue(2'b00, 3'd1, 3'd2, 6'd30);
    tick();
    issue(2'b00, 3'd1, 3'd2, 6'd31);
    tick();
    bus.in_valid = 1'b0;
    check("pre_rst_count", 32'(count), 2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus.out_valid), 0);
    check("arst_empty", 32'(empty), 1);
    check("arst_count", 32'(count), 0);
    check("arst_in_ready", 32'(bus.in_ready), 1);
    check("arst_data", 32'(bus.out_data), 0);
    tick();
    rst = 1'b0;
    issue(2'b00, 3'd4, 3'd5, 6'd9);
    tick();
    bus.in_valid = 1'b0;
    check("post_rst_data", 32'(bus.out_data), 9);
    check("post_rst_count", 32'(count), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Downstream stage of the 3-bit `arithmetic_unit`. Each cycle it can accept one issued operation: the 2-bit select, the 3-bit operands and the 6-bit result. It tags the result with status flags and queues it in a small FIFO, then drains it through a valid/ready handshake toward the output pins or a host reader. This decouples the purely combinational ALU from a consumer that cannot sample every cycle.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `RES_W`, default 6: ALU result width.
- `OP_W`, default 3: operand width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-high.
- `clear` in 1: synchronous flush.
- `in_valid` in 1: issue strobe from the ALU stage.
- `in_ready` out 1: buffer can accept.
- `in_sel` in 2: operation; 00 add, 01 sub, 10 mul, 11 div.
- `in_a`, `in_b` in `OP_W`: operands presented to the ALU.
- `in_result` in `RES_W`: ALU result.
- `out_valid` out 1: head entry present.
- `out_ready` in 1: consumer accepts the head entry.
- `out_data` out `RES_W`: head result.
- `out_sel` out 2: head operation.
- `out_zero` out 1: head result == 0.
- `out_div0` out 1: head was a divide with B == 0.
- `count` out `$clog2(DEPTH)+1`: occupancy.
- `full`, `empty` out 1: occupancy flags.
- `drop_cnt` out 4: saturating count of rejected issues.

## Operation
- Entry layout: {div0, zero, sel, result}, 2 + `RES_W` + 2 bits.
- Flags are computed at push time:
  - zero = (`in_result` == 0).
  - div0 = (`in_sel` == 2'b11) && (`in_b` == 0).
  - `in_result` is stored unmodified; no saturation.
- `in_ready` = !`full` (registered-state only; no combinational path from `out_ready`).
- Push when `in_valid` && `in_ready`: write at `wr_ptr`, then `wr_ptr`++ (wraps mod `DEPTH`).
- Pop when `out_valid` && `out_ready`: `rd_ptr`++ (wraps mod `DEPTH`).
- `out_valid` = !`empty`. `out_*` are driven from `mem[rd_ptr]`, and are don't-care while `out_valid` = 0.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- Full: `in_ready` = 0. Any `in_valid` in that cycle is dropped and `drop_cnt`++, saturating at 15. A pop in that same cycle does not rescue the drop.
- Empty: a pop is impossible because `out_valid` = 0, so `out_ready` is ignored.
- `clear` zeroes the pointers, `count` and `drop_cnt`. It overrides push, pop and drop in the same cycle. Memory contents are not cleared.
- `rst`: same effect as `clear`, but asynchronous. It may arrive mid-transfer; the in-flight entry is lost.

## Timing
- Reset values:
  - `out_valid` = 0, `empty` = 1, `full` = 0, `in_ready` = 1.
  - `count` = 0, `drop_cnt` = 0.
  - `out_data`, `out_sel`, `out_zero`, `out_div0` = 0, since memory is reset to 0.
- Latency: a push in cycle N makes the entry visible with `out_valid` = 1 in cycle N+1. There is no same-cycle bypass.
- `count`, `full`, `empty` and `in_ready` are all updated at the clock edge following the push or pop.
- Handshake rules:
  - The consumer may hold `out_ready` high continuously.
  - Once `out_valid` is high, the head entry stays stable until it is popped.
  - Sustained throughput is 1 entry per cycle when the buffer is not full.
- First-cycle behaviour after `rst` deassertion: normal operation.

## Structure
- Shared package `alu_pkg` holds:
  - Op encodings `OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`.
  - `RES_W` and `OP_W` constants.
  - Packed struct `alu_entry_t` {div0, zero, sel, result}.
  - Flag-generation function `alu_flags()`.
- One sub-module, `alu_fifo`: a generic synchronous FIFO.
  - Width and depth are parameters.
  - Ports: async-high `rst`, `clear`, push/pop, `count`/`full`/`empty`.
- `alu_result_buffer` wraps `alu_fifo` and adds flag generation and the drop counter.

## Test plan
- Reset, then push {sel=00, a=3, b=2, result=5}, with `out_ready` = 0 throughout → next cycle `out_valid` = 1, `out_data` = 5, `out_zero` = 0, `count` = 1; entry held steady.
- Push div {sel=11, a=5, b=0, result=0} → `out_div0` = 1, `out_zero` = 1. Push mul 7×7 = 49 → `out_data` = 49, flags 0.
- With `out_ready` = 0, push 5 entries back-to-back (results 1..5):
  - After the 4th push: `full` = 1, `in_ready` = 0, `count` = 4.
  - The 5th push is dropped: `drop_cnt` = 1.
  - Draining with `out_ready` = 1 then returns 1, 2, 3, 4 in order.
- Continuous push and pop for 10 cycles with `out_ready` = 1:
  - `count` holds at 1 and pointers wrap cleanly.
  - Output sequence equals the input sequence, delayed by 1 cycle.
- With `count` = 3, assert `clear` simultaneously with a push and a pop → next cycle `count` = 0, `empty` = 1, `drop_cnt` = 0. Assert `rst` mid-stream → outputs take their reset values immediately, without waiting for a clock.
